// File: rtl/io_retime_pkg.sv
// Shared limits and helpers for the io_retime pipeline: lane slicing and
// the width of the occupancy counter.
package io_retime_pkg;

    localparam int WIDTH_MIN    = 1;
    localparam int WIDTH_MAX    = 64;
    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 16;
    localparam int DEPTH_MIN    = 1;
    localparam int DEPTH_MAX    = 8;

    // Lowest bit index of a lane inside a packed multi-lane word.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    // Bits needed to hold an occupancy value in the range 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/io_retime_stage.sv
// One pipeline stage: a valid bit plus a data word, loaded together under
// control of the chain-wide load signal; flush clears only the valid bit.
module io_retime_stage #(
    parameter int             DW        = 64,
    parameter logic [DW-1:0]  INIT_WORD = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          valid,
    output logic [DW-1:0] data
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    // Next-state: flush wins; data only moves when a real word arrives.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Stage registers with asynchronous reset to the lane init pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= INIT_WORD;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/io_retime_pipe.sv
// Elastic multi-lane retiming pipeline of DEPTH stages with bubble collapse,
// synchronous flush and an occupancy count; outputs come straight from flops.
module io_retime_pipe
    import io_retime_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               CHANNELS = 4,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] INIT     = '0
) (
    input  logic                         CLK,
    input  logic                         ASYNCRESET,
    input  logic [CHANNELS*WIDTH-1:0]    I,
    input  logic                         I_valid,
    output logic                         I_ready,
    output logic [CHANNELS*WIDTH-1:0]    O,
    output logic                         O_valid,
    input  logic                         O_ready,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int DW = CHANNELS * WIDTH;
    localparam int CW = count_width(DEPTH);

    function automatic logic [DW-1:0] build_init(input logic [WIDTH-1:0] lane_val);
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w[lane_lsb(k, WIDTH) +: WIDTH] = lane_val;
        end
        return w;
    endfunction

    localparam logic [DW-1:0] INIT_WORD = build_init(INIT);

    logic [DEPTH-1:0] valid_s;
    logic [DEPTH-1:0] load_s;
    logic [DEPTH-1:0] in_valid_s;
    logic [DW-1:0]    data_s    [DEPTH];
    logic [DW-1:0]    in_data_s [DEPTH];
    logic [CW-1:0]    cnt_s;

    // Stage s may load unless it and every stage ahead of it is full and
    // the consumer is stalling; this is what collapses bubbles.
    always_comb begin
        logic all_full;
        load_s   = '0;
        all_full = 1'b1;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            all_full  = all_full & valid_s[s];
            load_s[s] = O_ready | ~all_full;
        end
    end

    // Occupancy is the popcount of the stage valid bits.
    always_comb begin
        cnt_s = '0;
        for (int s = 0; s < DEPTH; s++) begin
            cnt_s = cnt_s + CW'(valid_s[s]);
        end
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign in_valid_s[s] = I_valid;
            assign in_data_s[s]  = I;
        end else begin : g_body
            assign in_valid_s[s] = valid_s[s-1];
            assign in_data_s[s]  = data_s[s-1];
        end

        io_retime_stage #(
            .DW        (DW),
            .INIT_WORD (INIT_WORD)
        ) u_stage (
            .clk      (CLK),
            .rst      (ASYNCRESET),
            .load     (load_s[s]),
            .flush    (flush),
            .in_valid (in_valid_s[s]),
            .in_data  (in_data_s[s]),
            .valid    (valid_s[s]),
            .data     (data_s[s])
        );
    end

    assign I_ready = load_s[0] & ~flush;
    assign O       = data_s[DEPTH-1];
    assign O_valid = valid_s[DEPTH-1];
    assign count   = cnt_s;

endmodule

// File: tb/tb_io_retime_pipe.sv
// Directed, table-driven bench for io_retime_pipe: a DEPTH=2 x4x16 instance
// and a DEPTH=1 x1x1 instance, plus hand-written reset sequences.
module tb_io_retime_pipe;

    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic        ordy;
        logic        fl;
        logic        e_ir;
        logic        e_ov;
        logic [15:0] e_o;
        logic [1:0]  e_cnt;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        ASYNCRESET;
    logic [63:0] m_i;
    logic        m_iv;
    logic        m_ir;
    logic [63:0] m_o;
    logic        m_ov;
    logic        m_or;
    logic        m_fl;
    logic [1:0]  m_cnt;

    logic [0:0]  s_i;
    logic        s_iv;
    logic        s_ir;
    logic [0:0]  s_o;
    logic        s_ov;
    logic        s_or;
    logic        s_fl;
    logic [0:0]  s_cnt;

    io_retime_pipe #(
        .WIDTH    (16),
        .CHANNELS (4),
        .DEPTH    (2),
        .INIT     (16'h00A5)
    ) u_main (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .I          (m_i),
        .I_valid    (m_iv),
        .I_ready    (m_ir),
        .O          (m_o),
        .O_valid    (m_ov),
        .O_ready    (m_or),
        .flush      (m_fl),
        .count      (m_cnt)
    );

    io_retime_pipe #(
        .WIDTH    (1),
        .CHANNELS (1),
        .DEPTH    (1),
        .INIT     (1'b0)
    ) u_small (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .I          (s_i),
        .I_valid    (s_iv),
        .I_ready    (s_ir),
        .O          (s_o),
        .O_valid    (s_ov),
        .O_ready    (s_or),
        .flush      (s_fl),
        .count      (s_cnt)
    );

    localparam logic [63:0] INIT_WORD = 64'h00A5_00A5_00A5_00A5;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each lane carries a distinct value derived from the lane-0 value.
    function automatic logic [63:0] mk_word(input logic [15:0] d);
        logic [63:0] w;
        for (int k = 0; k < 4; k++) begin
            w[k*16 +: 16] = d + 16'(k) * 16'h1000;
        end
        return w;
    endfunction

    function automatic vec_t mkv(input logic iv, input logic [15:0] d, input logic ordy,
                                 input logic fl, input logic e_ir, input logic e_ov,
                                 input logic [15:0] e_o, input logic [1:0] e_cnt);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_o = e_o; v.e_cnt = e_cnt;
        return v;
    endfunction

    vec_t main_v[$];
    vec_t small_v[$];

    task automatic apply_main(input vec_t v, input int idx);
        m_iv = v.iv;
        m_i  = mk_word(v.d);
        m_or = v.ordy;
        m_fl = v.fl;
        #1;
        chk($sformatf("main[%0d].I_ready", idx), 64'(m_ir), 64'(v.e_ir));
        chk($sformatf("main[%0d].O_valid", idx), 64'(m_ov), 64'(v.e_ov));
        if (v.e_ov) chk($sformatf("main[%0d].O", idx), m_o, mk_word(v.e_o));
        chk($sformatf("main[%0d].count", idx), 64'(m_cnt), 64'(v.e_cnt));
        @(negedge CLK);
    endtask

    task automatic apply_small(input vec_t v, input int idx);
        s_iv = v.iv;
        s_i  = v.d[0];
        s_or = v.ordy;
        s_fl = v.fl;
        #1;
        chk($sformatf("small[%0d].I_ready", idx), 64'(s_ir), 64'(v.e_ir));
        chk($sformatf("small[%0d].O_valid", idx), 64'(s_ov), 64'(v.e_ov));
        if (v.e_ov) chk($sformatf("small[%0d].O", idx), 64'(s_o), 64'(v.e_o[0]));
        chk($sformatf("small[%0d].count", idx), 64'(s_cnt), 64'(v.e_cnt[0]));
        @(negedge CLK);
    endtask

    initial begin
        // Streaming 0x0001..0x0010, consumer always ready, then drain.
        for (int k = 0; k <= 18; k++) begin
            logic [1:0] c;
            c = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : (k <= 16) ? 2'd2 : (k == 17) ? 2'd1 : 2'd0;
            main_v.push_back(mkv(k < 16, (k < 16) ? 16'(k + 1) : 16'h0000, 1'b1, 1'b0,
                                 1'b1, (k >= 2 && k <= 17), 16'(k - 1), c));
        end
        // Backpressure: 5 stalled cycles, then release and drain.
        main_v.push_back(mkv(1'b1, 16'h0101, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0));
        main_v.push_back(mkv(1'b1, 16'h0102, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1));
        for (int k = 0; k < 4; k++)
            main_v.push_back(mkv(1'b1, 16'h0103, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0101, 2'd2));
        main_v.push_back(mkv(1'b1, 16'h0103, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0101, 2'd2));
        main_v.push_back(mkv(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0102, 2'd2));
        main_v.push_back(mkv(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0103, 2'd1));
        main_v.push_back(mkv(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0));
        // Bubble collapse, then flush with a word offered.
        main_v.push_back(mkv(1'b1, 16'h0201, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0));
        main_v.push_back(mkv(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1));
        main_v.push_back(mkv(1'b1, 16'h0202, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0201, 2'd1));
        main_v.push_back(mkv(1'b1, 16'h0203, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0201, 2'd2));
        main_v.push_back(mkv(1'b1, 16'h0204, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0201, 2'd2));
        main_v.push_back(mkv(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0));
        // Flush coinciding with an output transfer: word seen once, rest dropped.
        main_v.push_back(mkv(1'b1, 16'h0301, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0));
        main_v.push_back(mkv(1'b1, 16'h0302, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1));
        main_v.push_back(mkv(1'b1, 16'h0303, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0301, 2'd2));
        main_v.push_back(mkv(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0));

        // DEPTH=1 elastic register with alternating consumer readiness.
        small_v.push_back(mkv(1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0));
        small_v.push_back(mkv(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 2'd1));
        small_v.push_back(mkv(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 2'd1));
        small_v.push_back(mkv(1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 2'd1));
        small_v.push_back(mkv(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 2'd1));
        small_v.push_back(mkv(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 2'd1));
        small_v.push_back(mkv(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0));

        ASYNCRESET = 1'b1;
        m_i = '0; m_iv = 1'b0; m_or = 1'b0; m_fl = 1'b0;
        s_i = '0; s_iv = 1'b0; s_or = 1'b0; s_fl = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk("reset.O_valid", 64'(m_ov), 64'd0);
        chk("reset.O", m_o, INIT_WORD);
        chk("reset.count", 64'(m_cnt), 64'd0);
        chk("reset.small_O_valid", 64'(s_ov), 64'd0);
        ASYNCRESET = 1'b0;
        #1;
        chk("post_reset.I_ready", 64'(m_ir), 64'd1);
        chk("post_reset.small_I_ready", 64'(s_ir), 64'd1);
        @(negedge CLK);

        for (int i = 0; i < main_v.size(); i++) apply_main(main_v[i], i);

        // Asynchronous reset mid-cycle with two words in flight.
        m_iv = 1'b1; m_i = mk_word(16'h0401); m_or = 1'b0; m_fl = 1'b0;
        @(negedge CLK);
        m_i = mk_word(16'h0402);
        @(negedge CLK);
        m_iv = 1'b0;
        #1;
        chk("arst.pre_count", 64'(m_cnt), 64'd2);
        chk("arst.pre_O", m_o, mk_word(16'h0401));
        ASYNCRESET = 1'b1;
        #1;
        chk("arst.O_valid", 64'(m_ov), 64'd0);
        chk("arst.O", m_o, INIT_WORD);
        chk("arst.count", 64'(m_cnt), 64'd0);
        ASYNCRESET = 1'b0;
        #1;
        chk("arst.I_ready", 64'(m_ir), 64'd1);
        @(negedge CLK);
        #1;
        chk("arst.after_O_valid", 64'(m_ov), 64'd0);
        chk("arst.after_count", 64'(m_cnt), 64'd0);
        @(negedge CLK);

        for (int i = 0; i < small_v.size(); i++) apply_small(small_v[i], i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
